// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer
// Walks a register-init table and drives a byte-level I2C master with
// START / write-byte / STOP strobes. Each register entry becomes one
// transaction: START, {DEV_ADDR,W}, {reg_addr,reg_data[8]}, reg_data[7:0],
// STOP. Entries with the delay flag set insert a fixed wait instead.
//
// Ports
//   CLK_I2C, RST_I2C      clock, asynchronous active-high reset
//   start_trigger         run request (honoured only in IDLE/DONE/FAIL)
//   tbl_index / tbl_entry table lookup; tbl_entry is a combinational
//                         function of tbl_index {delay, reg_addr[6:0], reg_data[8:0]}
//   i2c_out, i2c_start, i2c_end, i2c_write   command strobes and byte to master
//   i2c_ready, i2c_error  master idle / NACK or bus fault (sampled in CMD_WAIT only)
//   busy, done, error     run status
//   fail_index            entry that exhausted its attempts
//
// Build option: define I2C_INIT_SEQUENCER_RETRY_EN to restart a failed entry
// up to MAX_RETRIES times; without it the first error ends the run in FAIL.
module i2c_init_sequencer #(
   parameter int         NUM_ENTRIES  = 10,
   parameter logic [6:0] DEV_ADDR     = 7'h1A,
   parameter int         DELAY_CYCLES = 50,
   parameter int         MAX_RETRIES  = 3
) (
   input  logic        CLK_I2C,
   input  logic        RST_I2C,
   input  logic        start_trigger,
   output logic [15:0] tbl_index,
   input  logic [16:0] tbl_entry,
   output logic [7:0]  i2c_out,
   output logic        i2c_start,
   output logic        i2c_end,
   output logic        i2c_write,
   input  logic        i2c_ready,
   input  logic        i2c_error,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] fail_index
);

`ifdef I2C_INIT_SEQUENCER_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   // A zero-length delay still occupies one DELAY cycle.
   localparam int DW = (DELAY_CYCLES < 1) ? 1 : $clog2(DELAY_CYCLES + 1);
   localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [DW-1:0] DLAST = DW'((DELAY_CYCLES <= 1) ? 0 : DELAY_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, FETCH, CMD, CMD_WAIT, DELAY, RECOVER, DONE, FAIL} state_t;

   state_t        state, state_n;
   logic [2:0]    step, step_n;
   logic [15:0]   entry, entry_n;      // {reg_addr, reg_data} of the active entry
   logic [DW-1:0] dcnt, dcnt_n;
   logic [RW-1:0] retry, retry_n;
   logic          rec_sent, rec_n;     // RECOVER has already issued its STOP
   logic [15:0]   idx_n, fidx_n;

   always_ff @(posedge CLK_I2C or posedge RST_I2C) begin
      if (RST_I2C) begin
         state      <= IDLE;
         step       <= '0;
         entry      <= '0;
         dcnt       <= '0;
         retry      <= '0;
         rec_sent   <= 1'b0;
         tbl_index  <= '0;
         fail_index <= '0;
      end else begin
         state      <= state_n;
         step       <= step_n;
         entry      <= entry_n;
         dcnt       <= dcnt_n;
         retry      <= retry_n;
         rec_sent   <= rec_n;
         tbl_index  <= idx_n;
         fail_index <= fidx_n;
      end
   end

   always_comb begin
      state_n   = state;
      step_n    = step;
      entry_n   = entry;
      dcnt_n    = dcnt;
      retry_n   = retry;
      rec_n     = rec_sent;
      idx_n     = tbl_index;
      fidx_n    = fail_index;
      i2c_out   = 8'h00;
      i2c_start = 1'b0;
      i2c_end   = 1'b0;
      i2c_write = 1'b0;
      busy      = !(state inside {IDLE, DONE, FAIL});
      done      = (state == DONE);
      error     = (state == FAIL);

      case (state)
         IDLE, DONE, FAIL: begin
            if (start_trigger) begin
               state_n = FETCH;
               idx_n   = '0;
               retry_n = '0;
               fidx_n  = '0;
            end
         end
         FETCH: begin
            if (tbl_index == 16'(NUM_ENTRIES)) begin
               state_n = DONE;
            end else if (tbl_entry[16]) begin
               state_n = DELAY;
               dcnt_n  = '0;
            end else begin
               state_n = CMD;
               step_n  = '0;
               entry_n = tbl_entry[15:0];
            end
         end
         CMD: begin
            // entry[15:8] is {reg_addr, reg_data[8]} by construction.
            case (step)
               3'd1:    i2c_out = {DEV_ADDR, 1'b0};
               3'd2:    i2c_out = entry[15:8];
               3'd3:    i2c_out = entry[7:0];
               default: i2c_out = 8'h00;
            endcase
            if (i2c_ready) begin
               case (step)
                  3'd0:    i2c_start = 1'b1;
                  3'd4:    i2c_end   = 1'b1;
                  default: i2c_write = 1'b1;
               endcase
               state_n = CMD_WAIT;
            end
         end
         CMD_WAIT: begin
            if (i2c_error) begin
               state_n = RECOVER;
               rec_n   = 1'b0;
            end else if (step == 3'd4) begin
               state_n = FETCH;
               idx_n   = tbl_index + 16'd1;
               retry_n = '0;
            end else begin
               state_n = CMD;
               step_n  = step + 3'd1;
            end
         end
         RECOVER: begin
            if (!rec_sent) begin
               if (i2c_ready) begin
                  i2c_end = 1'b1;
                  rec_n   = 1'b1;
               end
            end else if (RETRY_EN && (retry < RW'(MAX_RETRIES))) begin
               state_n = CMD;
               step_n  = '0;
               retry_n = retry + RW'(1);
            end else begin
               state_n = FAIL;
               fidx_n  = tbl_index;
            end
         end
         DELAY: begin
            if (dcnt >= DLAST) begin
               state_n = FETCH;
               idx_n   = tbl_index + 16'd1;
            end else begin
               dcnt_n = dcnt + DW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Self-checking bench for i2c_init_sequencer (default parameters).
// A table of register vectors with hand-computed wire bytes feeds both the
// DUT's lookup memory and a scoreboard queue of expected strobes; a monitor
// pops and compares every strobe and injects i2c_error after selected
// address bytes. Expectations follow I2C_INIT_SEQUENCER_RETRY_EN if defined.
`timescale 1ns/1ps
module tb_i2c_init_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_trigger;
   logic [15:0] tbl_index;
   logic [16:0] tbl_entry;
   logic [7:0]  i2c_out;
   logic        i2c_start, i2c_end, i2c_write;
   logic        i2c_ready, i2c_error;
   logic        busy, done, error;
   logic [15:0] fail_index;

   always #5 clk = ~clk;

   i2c_init_sequencer dut (
      .CLK_I2C(clk), .RST_I2C(rst), .start_trigger(start_trigger),
      .tbl_index(tbl_index), .tbl_entry(tbl_entry), .i2c_out(i2c_out),
      .i2c_start(i2c_start), .i2c_end(i2c_end), .i2c_write(i2c_write),
      .i2c_ready(i2c_ready), .i2c_error(i2c_error),
      .busy(busy), .done(done), .error(error), .fail_index(fail_index)
   );

   logic [16:0] tbl_mem [0:15];
   assign tbl_entry = (tbl_index < 16'd16) ? tbl_mem[tbl_index[3:0]] : 17'h0;

   typedef struct packed { logic [1:0] kind; logic [7:0] data; } exp_t;  // kind: 0 start, 1 write, 2 end
   typedef struct { logic [6:0] addr; logic [8:0] rdata; logic [7:0] b2; logic [7:0] b3; } vec_t;

   vec_t vecs [0:8];
   exp_t exp_q [$];
   int total = 0, passed = 0;
   int strobe_cnt = 0, last_strobe_cyc = 0, cyc = 0;
   int inj_entry = -1, inj_limit = 0, inj_hits = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic push_entry(input logic [7:0] b2, input logic [7:0] b3);
      exp_q.push_back('{2'd0, 8'h00});
      exp_q.push_back('{2'd1, 8'h34});
      exp_q.push_back('{2'd1, b2});
      exp_q.push_back('{2'd1, b3});
      exp_q.push_back('{2'd2, 8'h00});
   endtask

   // Attempt cut short by an error on the address byte: START, addr, recovery STOP.
   task automatic push_abort();
      exp_q.push_back('{2'd0, 8'h00});
      exp_q.push_back('{2'd1, 8'h34});
      exp_q.push_back('{2'd2, 8'h00});
   endtask

   task automatic pulse_start(input logic exp_busy);
      @(posedge clk); #1 start_trigger = 1'b1;
      @(posedge clk); #1 start_trigger = 1'b0;
      chk("busy_after_start", 32'(busy), 32'(exp_busy));
   endtask

   task automatic wait_strobes(input int target, input int bound);
      int n;
      n = 0;
      while (strobe_cnt < target && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      if (strobe_cnt < target) chk("timeout_strobes", strobe_cnt, target);
   endtask

   task automatic wait_end(output int end_cyc);
      int n;
      n = 0;
      end_cyc = 0;
      while (!(done || error) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      end_cyc = cyc;
      if (!(done || error)) chk("timeout_end", 32'(done), 1);
   endtask

   // Strobe monitor and error-injecting master model.
   initial begin : mon
      int   wr_num;
      logic prev;
      logic [1:0] k;
      exp_t e;
      wr_num = 0; prev = 1'b0; i2c_error = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || !(i2c_start || i2c_end || i2c_write)) prev = 1'b0;
         else begin
            chk("strobe_onehot", 32'($countones({i2c_start, i2c_end, i2c_write})), 1);
            chk("strobe_gap", 32'(prev), 0);
            strobe_cnt++;
            last_strobe_cyc = cyc;
            k = i2c_start ? 2'd0 : (i2c_write ? 2'd1 : 2'd2);
            if (exp_q.size() == 0) chk("unexpected_strobe", 32'(k) + 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("strobe_kind", 32'(k), 32'(e.kind));
               if (i2c_write) chk("strobe_byte", 32'(i2c_out), 32'(e.data));
            end
            prev = 1'b1;
            if (i2c_start) wr_num = 0;
            else if (i2c_write) begin
               if (wr_num == 0 && int'(tbl_index) == inj_entry && inj_hits < inj_limit) begin
                  inj_hits++;
                  @(posedge clk); #1 i2c_error = 1'b1;
                  @(posedge clk); #1 i2c_error = 1'b0;
                  prev = 1'b0;
               end
               wr_num++;
            end
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1);
   end

   initial begin : main
      int base, end_cyc, hits0;
      rst = 1'b1; start_trigger = 1'b0; i2c_ready = 1'b1;
      vecs[0] = '{7'h09, 9'h101, 8'h13, 8'h01};
      vecs[1] = '{7'h7F, 9'h1FF, 8'hFF, 8'hFF};
      vecs[2] = '{7'h00, 9'h000, 8'h00, 8'h00};
      vecs[3] = '{7'h55, 9'h0AA, 8'hAA, 8'hAA};
      vecs[4] = '{7'h2A, 9'h155, 8'h55, 8'h55};
      vecs[5] = '{7'h01, 9'h100, 8'h03, 8'h00};
      vecs[6] = '{7'h40, 9'h080, 8'h80, 8'h80};
      vecs[7] = '{7'h12, 9'h034, 8'h24, 8'h34};
      vecs[8] = '{7'h3C, 9'h1C3, 8'h79, 8'hC3};
      for (int i = 0; i < 16; i++) tbl_mem[i] = 17'h0;
      for (int i = 0; i < 9; i++) tbl_mem[i] = {1'b0, vecs[i].addr, vecs[i].rdata};
      tbl_mem[9] = 17'h10000;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_index", 32'(tbl_index), 0);
      chk("rst_fail_index", 32'(fail_index), 0);
      chk("rst_strobes", 32'({i2c_start, i2c_end, i2c_write}), 0);
      rst = 1'b0;

      // Run 1: full table, ready stall at step3, ignored mid-run start
      base = strobe_cnt;
      for (int i = 0; i < 9; i++) push_entry(vecs[i].b2, vecs[i].b3);
      pulse_start(1'b1);
      wait_strobes(base + 8, 100);
      i2c_ready = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("stall_no_strobe", strobe_cnt, base + 8);
      i2c_ready = 1'b1;
      wait_strobes(base + 12, 100);
      pulse_start(1'b1);
      chk("idx_after_ignored_start", 32'(tbl_index), 2);
      wait_end(end_cyc);
      chk("run1_done", 32'(done), 1);
      chk("run1_error", 32'(error), 0);
      chk("run1_busy", 32'(busy), 0);
      chk("run1_index", 32'(tbl_index), 10);
      chk("run1_delay_gap", end_cyc - last_strobe_cyc, 54);
      chk("run1_queue_empty", exp_q.size(), 0);
      chk("run1_strobe_count", strobe_cnt - base, 45);

      // Run 2: error on the address byte of entry 2, three times
      hits0 = inj_hits;
      inj_entry = 2; inj_limit = inj_hits + 3;
      push_entry(vecs[0].b2, vecs[0].b3);
      push_entry(vecs[1].b2, vecs[1].b3);
`ifdef I2C_INIT_SEQUENCER_RETRY_EN
      repeat (3) push_abort();
      for (int i = 2; i < 9; i++) push_entry(vecs[i].b2, vecs[i].b3);
`else
      push_abort();
`endif
      pulse_start(1'b1);
      chk("run2_done_cleared", 32'(done), 0);
      wait_end(end_cyc);
`ifdef I2C_INIT_SEQUENCER_RETRY_EN
      chk("run2_done", 32'(done), 1);
      chk("run2_error", 32'(error), 0);
      chk("run2_injected", inj_hits - hits0, 3);
      chk("run2_index", 32'(tbl_index), 10);
`else
      chk("run2_done", 32'(done), 0);
      chk("run2_error", 32'(error), 1);
      chk("run2_fail_index", 32'(fail_index), 2);
`endif
      chk("run2_queue_empty", exp_q.size(), 0);

      // Run 3: persistent error on entry 4
      inj_entry = 4; inj_limit = inj_hits + 1000;
      for (int i = 0; i < 4; i++) push_entry(vecs[i].b2, vecs[i].b3);
`ifdef I2C_INIT_SEQUENCER_RETRY_EN
      repeat (4) push_abort();
`else
      push_abort();
`endif
      pulse_start(1'b1);
      chk("run3_error_cleared", 32'(error), 0);
      chk("run3_fail_index_cleared", 32'(fail_index), 0);
      wait_end(end_cyc);
      repeat (10) @(negedge clk);
      chk("run3_error", 32'(error), 1);
      chk("run3_done", 32'(done), 0);
      chk("run3_busy", 32'(busy), 0);
      chk("run3_fail_index", 32'(fail_index), 4);
      chk("run3_queue_empty", exp_q.size(), 0);
      inj_entry = -1;

      // Run 4: reset in the middle of the delay entry
      for (int i = 0; i < 9; i++) push_entry(vecs[i].b2, vecs[i].b3);
      pulse_start(1'b1);
      begin
         int n;
         n = 0;
         while (tbl_index != 16'd9 && n < 1000) begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("run4_reached_delay", 32'(tbl_index), 9);
      repeat (5) @(posedge clk);
      #1 chk("run4_busy_in_delay", 32'(busy), 1);
      base = strobe_cnt;
      rst = 1'b1;
      #1;
      chk("run4_rst_busy", 32'(busy), 0);
      chk("run4_rst_index", 32'(tbl_index), 0);
      chk("run4_rst_outs", 32'({done, error, i2c_start, i2c_end, i2c_write, i2c_out, fail_index}), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("run4_no_strobes", strobe_cnt, base);
      chk("run4_idle_busy", 32'(busy), 0);
      chk("run4_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/i2c_init_sequencer.md
I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 SHALL provide parameter NUM_ENTRIES, default 10, number of table entries executed per run.
REQ-002 SHALL provide parameter DEV_ADDR, default 7'h1A, 7-bit I2C target address.
REQ-003 SHALL provide parameter DELAY_CYCLES, default 50, wait length for a delay entry, in CLK_I2C cycles.
REQ-004 SHALL provide parameter MAX_RETRIES, default 3, retries allowed per entry after an I2C error.
REQ-005 SHALL have ports, in order: CLK_I2C in 1, sole clock; RST_I2C in 1, asynchronous active-high reset; start_trigger in 1, run request; tbl_index out 16, current table entry; tbl_entry in 17, {delay_flag, reg_addr[6:0], reg_data[8:0]}, combinational lookup of tbl_index; i2c_out out 8, byte to master; i2c_start out 1, START pulse; i2c_end out 1, STOP pulse; i2c_write out 1, write-byte pulse; i2c_ready in 1, master idle; i2c_error in 1, NACK/bus fault; busy out 1; done out 1; error out 1; fail_index out 16, entry that failed.

Function
REQ-006 SHALL use states IDLE, FETCH, CMD, CMD_WAIT, DELAY, RECOVER, DONE, FAIL.
REQ-007 SHALL, in IDLE, DONE or FAIL, on start_trigger=1 clear done, error, tbl_index and retry count, set busy=1 and enter FETCH next cycle; start_trigger SHALL be ignored in all other states.
REQ-008 SHALL, in FETCH, enter DONE (busy=0, done=1) if tbl_index==NUM_ENTRIES, else DELAY if tbl_entry[16]=1, else CMD with step=0 and tbl_entry captured.
REQ-009 SHALL issue per register entry five commands: step0 i2c_start; step1 i2c_write with i2c_out={DEV_ADDR,1'b0}; step2 i2c_write with i2c_out={reg_addr,reg_data[8]}; step3 i2c_write with i2c_out=reg_data[7:0]; step4 i2c_end.
REQ-010 SHALL, in CMD, wait while i2c_ready=0; on i2c_ready=1 drive exactly one command strobe high for one cycle with i2c_out valid that cycle, then enter CMD_WAIT.
REQ-011 SHALL, in CMD_WAIT (exactly one cycle), deassert all strobes and sample i2c_error; on error enter RECOVER; else step4 -> tbl_index+1, clear retry count, FETCH; other steps -> step+1, CMD.
REQ-012 SHALL, in RECOVER, on i2c_ready=1 pulse i2c_end one cycle, then after one cycle enter CMD at step0 with retry count+1 if retry count<MAX_RETRIES, else FAIL.
REQ-013 SHALL, in FAIL, hold busy=0, error=1, done=0, fail_index=tbl_index of failing entry until next start_trigger or reset.
REQ-014 SHALL, in DELAY, count DELAY_CYCLES cycles (counter width $clog2(DELAY_CYCLES+1)), then tbl_index+1 and FETCH; DELAY_CYCLES=0 SHALL behave as one cycle.
REQ-015 SHALL keep i2c_start, i2c_end, i2c_write mutually exclusive and never high two consecutive cycles.
REQ-016 SHALL hold tbl_index stable except on the single increment/clear cycles of REQ-007/011/014.
REQ-017 SHALL treat i2c_error outside CMD_WAIT as don't-care.

Reset
REQ-018 SHALL, on RST_I2C=1, asynchronously force state IDLE and all outputs, tbl_index, fail_index, step, retry and delay counters to 0.
REQ-019 SHALL, on reset mid-transaction, emit no further strobes; bus recovery is the master's responsibility.

Configuration
REQ-020 SHALL honour macro I2C_INIT_SEQUENCER_RETRY_EN: defined -> retries per REQ-012; undefined -> RECOVER issues STOP then enters FAIL directly, MAX_RETRIES ignored.

Verification
REQ-021 Default params, table of 9 register entries + delay at index 9, master always ready -> 45 strobes in order, entry0 bytes 0x34, {reg_addr,d8}, d[7:0]; 50-cycle gap; done=1 afterwards.
REQ-022 Entry reg_addr=7'h09, reg_data=9'h101 -> step2 i2c_out=0x13, step3 i2c_out=0x01.
REQ-023 RETRY_EN defined, i2c_error=1 on step1 of entry 2 three times then clear -> three STOPs, entry 2 restarted, run completes done=1 error=0.
REQ-024 RETRY_EN defined, error persistent on entry 4 -> 4 attempts, FAIL, error=1, fail_index=4; RETRY_EN undefined -> one attempt, fail_index=4.
REQ-025 i2c_ready held 0 for 20 cycles at step3 -> no strobe until ready rises; start_trigger during busy ignored; RST_I2C mid-DELAY -> all outputs 0 immediately.
